// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides: one-cycle base ops and illegal ops,
// plus a fixed-latency unsigned shift-add multiplier (one multiplier bit per cycle).
module alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic [4:0]       flags
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic             alu_load;
  logic             mul_done;
  logic             mul_last;

  logic [WIDTH-1:0] mul_a_q;
  logic [PW-1:0]    mul_p_q, mul_p_d;
  logic [WIDTH:0]   mul_sum;
  logic [SHW-1:0]   cnt_q;

  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf, alu_err, alu_zero, alu_neg;
  logic             mul_zero, mul_neg, mul_carry;

  assign accept   = in_valid && in_ready;
  assign alu_load = accept && (op != OP_MUL);
  assign mul_last = (cnt_q == SHW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && (op == OP_MUL)) state_d = S_MUL;
      S_MUL:   if (mul_last)                 state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; rst_n gates in_ready so nothing is taken while reset is held
  always_comb begin
    in_ready = 1'b0;
    mul_done = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = rst_n && (!out_valid || out_ready);
      S_MUL:   mul_done = mul_last;
      default: ;
    endcase
  end

  // Single-cycle datapath and flags
  always_comb begin
    add_w     = {1'b0, a} + {1'b0, b};
    sub_w     = {1'b0, a} - {1'b0, b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = add_w[WIDTH-1:0];
        alu_carry = add_w[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sub_w[WIDTH-1:0];
        alu_carry = sub_w[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL:  alu_res = a << b[SHW-1:0];
      OP_SHR:  alu_res = a >> b[SHW-1:0];
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: alu_err = 1'b1;
    endcase
    alu_zero = (alu_res == '0);
    alu_neg  = alu_res[WIDTH-1];
  end

  // One shift-add step: conditionally add multiplicand into the high half, then shift right
  always_comb begin
    mul_sum   = {1'b0, mul_p_q[PW-1:WIDTH]} + {1'b0, (mul_p_q[0] ? mul_a_q : {WIDTH{1'b0}})};
    mul_p_d   = {mul_sum, mul_p_q[WIDTH-1:1]};
    mul_zero  = (mul_p_d == '0);
    mul_neg   = mul_p_d[PW-1];
    mul_carry = (mul_p_d[PW-1:WIDTH] != '0);
  end

  // Multiplier operand/product registers and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q <= '0;
      mul_p_q <= '0;
      cnt_q   <= '0;
    end else if (accept && (op == OP_MUL)) begin
      mul_a_q <= a;
      mul_p_q <= {{WIDTH{1'b0}}, b};
      cnt_q   <= '0;
    end else if (state_q == S_MUL) begin
      mul_p_q <= mul_p_d;
      cnt_q   <= cnt_q + SHW'(1);
    end
  end

  // Output register: load a new result, otherwise drop valid once it is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
      res_hi    <= '0;
      flags     <= '0;
    end else if (alu_load) begin
      out_valid <= 1'b1;
      res       <= alu_res;
      res_hi    <= '0;
      flags     <= {alu_err, alu_ovf, alu_neg, alu_zero, alu_carry};
    end else if (mul_done) begin
      out_valid <= 1'b1;
      res       <= mul_p_d[WIDTH-1:0];
      res_hi    <= mul_p_d[PW-1:WIDTH];
      flags     <= {1'b0, 1'b0, mul_neg, mul_zero, mul_carry};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
